// File: rtl/gpr_debug_reader.sv
// rtl/gpr_debug_reader.sv - debug-side sequencer walking consecutive GPR reads
//
// Purpose: accepts a host read command (start index + count minus 1), issues one
// 4-phase dbg_gpr_req/dbg_gpr_ack handshake per index and returns each captured
// 64-bit value on a valid/ready response stream.
// Optional feature macro: GPR_DBG_TIMEOUT_EN (REQ-phase ack timeout of
// TIMEOUT_CYCLES cycles).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         host command handshake (ready only in IDLE)
//   cmd_addr[6:0], cmd_len[5:0] first GPR index, number of reads minus 1
//   rsp_valid/rsp_ready         response handshake
//   rsp_data[63:0]              captured value (0 on timeout abort)
//   rsp_last, rsp_err           final response of command, timeout abort flag
//   dbg_gpr_req, dbg_gpr_addr   request and index to the register file
//   dbg_gpr_ack, dbg_gpr_data   register-file ack and read data

module gpr_debug_reader
  #(parameter int TIMEOUT_CYCLES = 256)
  (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [5:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        dbg_gpr_req,
  output logic [6:0]  dbg_gpr_addr,
  input  logic        dbg_gpr_ack,
  input  logic [63:0] dbg_gpr_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        req_q, req_d;
  logic [6:0]  addr_q, addr_d;
  logic [5:0]  remaining_q, remaining_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_last_q, rsp_last_d;

`ifdef GPR_DBG_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
  // Set when the current REQ gave up waiting; reported in RELEASE.
  logic               abort_q, abort_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      req_q       <= 1'b0;
      addr_q      <= 7'd0;
      remaining_q <= 6'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 64'd0;
      rsp_last_q  <= 1'b0;
`ifdef GPR_DBG_TIMEOUT_EN
      timer_q     <= '0;
      abort_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
`ifdef GPR_DBG_TIMEOUT_EN
      timer_q     <= timer_d;
      abort_q     <= abort_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    req_d       = req_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
`ifdef GPR_DBG_TIMEOUT_EN
    timer_d     = timer_q;
    abort_d     = abort_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // cmd_ready is registered high throughout IDLE.
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          req_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = S_REQ;
`ifdef GPR_DBG_TIMEOUT_EN
          timer_d     = '0;
          abort_d     = 1'b0;
`endif
        end
      end

      S_REQ: begin
        // A deferred ack just keeps us here; data is only sampled with ack.
        if (dbg_gpr_ack) begin
          rsp_data_d = dbg_gpr_data;
          req_d      = 1'b0;
          state_d    = S_RELEASE;
        end
`ifdef GPR_DBG_TIMEOUT_EN
        else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = 64'd0;
          req_d      = 1'b0;
          abort_d    = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
`endif
      end

      S_RELEASE: begin
        // Wait for the ack to fall so the next request never overlaps it.
        // A late ack after an abort is ignored here: nothing is sampled.
        if (!dbg_gpr_ack) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = (remaining_q == 6'd0);
          state_d     = S_RESP;
`ifdef GPR_DBG_TIMEOUT_EN
          rsp_err_d   = abort_q;
          if (abort_q) begin
            rsp_last_d = 1'b1;
          end
`endif
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            addr_d      = addr_q + 7'd1;
            remaining_d = remaining_q - 6'd1;
            req_d       = 1'b1;
            state_d     = S_REQ;
`ifdef GPR_DBG_TIMEOUT_EN
            timer_d     = '0;
`endif
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready    = cmd_ready_q;
  assign dbg_gpr_req  = req_q;
  assign dbg_gpr_addr = addr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_last     = rsp_last_q;
`ifdef GPR_DBG_TIMEOUT_EN
  assign rsp_err      = rsp_err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_debug_reader.sv
// tb/tb_gpr_debug_reader.sv - self-checking bench for gpr_debug_reader
module tb_gpr_debug_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        dbg_gpr_req;
  logic [6:0]  dbg_gpr_addr;
  logic        dbg_gpr_ack;
  logic [63:0] dbg_gpr_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpr_debug_reader #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rsp_err     (rsp_err),
    .dbg_gpr_req (dbg_gpr_req),
    .dbg_gpr_addr(dbg_gpr_addr),
    .dbg_gpr_ack (dbg_gpr_ack),
    .dbg_gpr_data(dbg_gpr_data)
  );

  // Register-file model: ack after stall_cfg cycles of req, held while req,
  // falls one cycle after req drops. Data is only meaningful while ack is high.
  logic [63:0] gpr [128];
  int          stall_cfg  = 0;
  int          stall_left = 0;
  logic        ack_m      = 1'b0;

  always @(posedge clk) begin
    if (!dbg_gpr_req) begin
      ack_m      <= 1'b0;
      stall_left <= stall_cfg;
    end else if (stall_left > 0) begin
      stall_left <= stall_left - 1;
    end else begin
      ack_m <= 1'b1;
    end
  end

  assign dbg_gpr_ack  = ack_m;
  assign dbg_gpr_data = ack_m ? gpr[dbg_gpr_addr] : 64'hBADD_BADD_BADD_BADD;

  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [6:0]  prev_addr = 7'd0;
  logic [6:0]  addr_seen [$];
  int          last_latency;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; track request
  // issue (no overlap with a live ack, address held while requesting).
  task automatic tick();
    @(posedge clk);
    #1;
    if (dbg_gpr_req && !prev_req) begin
      check("req_no_overlap", 64'(prev_ack), 64'd0);
      addr_seen.push_back(dbg_gpr_addr);
    end
    if (dbg_gpr_req && prev_req) begin
      check("addr_stable", 64'(dbg_gpr_addr), 64'(prev_addr));
    end
    prev_req  = dbg_gpr_req;
    prev_ack  = dbg_gpr_ack;
    prev_addr = dbg_gpr_addr;
  endtask

  task automatic run_cmd(input logic [6:0] a, input logic [5:0] l, input int stall,
                         input bit mutate, input int bp_idx, input bit timeout);
    int          n;
    int          cyc;
    logic [6:0]  ea;
    logic [63:0] exp_data;
    n = timeout ? 1 : int'(l) + 1;
    stall_cfg = stall;
    addr_seen.delete();
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 7'($urandom);
    cmd_len   = 6'($urandom);
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (!rsp_valid && cyc < 300) begin
        tick();
        cyc++;
        if (mutate && i == 0 && cyc == 5) gpr[a] = {$urandom, $urandom};
      end
      check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
      if (i == 0) last_latency = cyc;
      ea = a + 7'(i);
      exp_data = timeout ? 64'd0 : gpr[ea];
      check("rsp_data", rsp_data, exp_data);
      check("rsp_last", 64'(rsp_last), 64'(i == n - 1));
      check("rsp_err", 64'(rsp_err), 64'(timeout));
      if (i == bp_idx) begin
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
          cmd_addr = 7'($urandom);
          cmd_len  = 6'($urandom);
          tick();
          check("bp_valid", 64'(rsp_valid), 64'd1);
          check("bp_data", rsp_data, exp_data);
          check("bp_last", 64'(rsp_last), 64'(i == n - 1));
          check("bp_err", 64'(rsp_err), 64'(timeout));
          check("bp_no_req", 64'(dbg_gpr_req), 64'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      tick();
      check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    end
    check("cmd_ready_done", 64'(cmd_ready), 64'd1);
    check("addr_count", 64'(addr_seen.size()), 64'(n));
    for (int i = 0; i < addr_seen.size() && i < n; i++) begin
      ea = a + 7'(i);
      check("dbg_addr", 64'(addr_seen[i]), 64'(ea));
    end
  endtask

  initial begin
    logic [6:0] ra;
    logic [5:0] rl;
    int         bp;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 7'd0;
    cmd_len   = 6'd0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 128; i++) gpr[i] = {$urandom, $urandom};
    gpr[5] = 64'hDEAD_BEEF_0123_4567;

    repeat (3) tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_req", 64'(dbg_gpr_req), 64'd0);
    check("rst_addr", 64'(dbg_gpr_addr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    tick();

    // Single read with minimum latency.
    run_cmd(7'd5, 6'd0, 0, 1'b0, -1, 1'b0);
    check("single_latency", 64'(last_latency), 64'd4);

    // Burst with backpressure on the second response.
    run_cmd(7'd30, 6'd3, 0, 1'b0, 1, 1'b0);

    // Index wrap 127 -> 0.
    run_cmd(7'd127, 6'd1, 0, 1'b0, -1, 1'b0);

    // Ack withheld 10 cycles; the register changes while the port is busy.
    run_cmd(7'd44, 6'd1, 10, 1'b1, -1, 1'b0);
    check("stall_latency", 64'(last_latency), 64'd14);

    // Longest command, wrapping through index 0.
    run_cmd(7'd100, 6'd63, 0, 1'b0, 40, 1'b0);

    // Randomized commands.
    for (int k = 0; k < 8; k++) begin
      ra = 7'($urandom_range(0, 127));
      rl = 6'($urandom_range(0, 7));
      bp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(rl))) : -1;
      run_cmd(ra, rl, int'($urandom_range(0, 3)), 1'b0, bp, 1'b0);
    end

`ifdef GPR_DBG_TIMEOUT_EN
    // Ack never arrives: single aborted response, remaining burst dropped.
    run_cmd(7'd12, 6'd5, 100000, 1'b0, -1, 1'b1);
    run_cmd(7'd13, 6'd0, 0, 1'b0, -1, 1'b0);
`endif

    // Reset while stuck in REQ.
    stall_cfg = 100000;
    cmd_valid = 1'b1;
    cmd_addr  = 7'd9;
    cmd_len   = 6'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check("mid_req_before_rst", 64'(dbg_gpr_req), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_req", 64'(dbg_gpr_req), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_addr", 64'(dbg_gpr_addr), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;

    // Reset while the register file holds ack, then recover.
    stall_cfg = 0;
    repeat (2) tick();
    cmd_valid = 1'b1;
    cmd_addr  = 7'd20;
    cmd_len   = 6'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("ack_rst_req", 64'(dbg_gpr_req), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    run_cmd(7'd21, 6'd2, 1, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
